// File: rtl/bcd_modulo_counter_pkg.sv
// bcd_modulo_counter_pkg: shared BCD digit type, digit limit and decimal-to-BCD conversion.
package bcd_modulo_counter_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX_DIGIT = 4'd9;
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with load, range wrap, and 0-9 up/down stepping.
module bcd_digit
  import bcd_modulo_counter_pkg::*;
#(
  parameter bcd_t RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  logic wrap,
  input  bcd_t load_val,
  input  bcd_t wrap_to,
  output bcd_t q,
  output logic at_nine,
  output logic at_zero
);
  bcd_t q_n;
  assign at_nine = q == BCD_MAX_DIGIT;
  assign at_zero = q == '0;
  always_comb
    q_n = load ? load_val :
          wrap ? wrap_to :
          inc  ? (at_nine ? '0 : q + 4'd1) :
          dec  ? (at_zero ? BCD_MAX_DIGIT : q - 4'd1) : q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RESET_VAL;
    else q <= q_n;
endmodule

// File: rtl/bcd_modulo_counter.sv
// bcd_modulo_counter: two-digit BCD up/down counter over [MIN_COUNT..MAX_COUNT] with wrap,
// checked parallel load and combinational carry/borrow for cascading.
module bcd_modulo_counter
  import bcd_modulo_counter_pkg::*;
#(
  parameter int MIN_COUNT   = 0,
  parameter int MAX_COUNT   = 59,
  parameter int RESET_COUNT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t load_msd,
  input  bcd_t load_lsd,
  output logic carry_out,
  output logic borrow_out,
  output logic load_err,
  output bcd_t data_msd,
  output bcd_t data_lsd
);
  localparam logic [7:0] MIN_B = to_bcd2(MIN_COUNT);
  localparam logic [7:0] MAX_B = to_bcd2(MAX_COUNT);
  localparam logic [7:0] RST_B = to_bcd2(RESET_COUNT);
  if (MIN_COUNT < 0 || MIN_COUNT > 98 || MAX_COUNT <= MIN_COUNT || MAX_COUNT > 99 ||
      RESET_COUNT < MIN_COUNT || RESET_COUNT > MAX_COUNT) begin : g_bad_params
    $error("bcd_modulo_counter: illegal MIN/MAX/RESET parameters");
  end
  logic [7:0] count, ld;
  logic up, dn, legal, do_load, wrap, lsd_nine, lsd_zero;
  logic [1:0] msd_flags_unused;
  assign count = {data_msd, data_lsd};
  assign ld = {load_msd, load_lsd};
  // BCD digits <=9 compare correctly as plain 8-bit values
  assign legal = load_msd <= BCD_MAX_DIGIT && load_lsd <= BCD_MAX_DIGIT && ld >= MIN_B && ld <= MAX_B;
  assign do_load = load & legal;
  assign up = inc & ~dec & ~load;
  assign dn = dec & ~inc & ~load;
  assign carry_out = up & (count == MAX_B);
  assign borrow_out = dn & (count == MIN_B);
  assign wrap = carry_out | borrow_out;
  bcd_digit #(.RESET_VAL(RST_B[3:0])) u_lsd (
    .clk(clk), .rst_n(rst_n), .inc(up), .dec(dn), .load(do_load), .wrap(wrap),
    .load_val(load_lsd), .wrap_to(carry_out ? MIN_B[3:0] : MAX_B[3:0]),
    .q(data_lsd), .at_nine(lsd_nine), .at_zero(lsd_zero)
  );
  bcd_digit #(.RESET_VAL(RST_B[7:4])) u_msd (
    .clk(clk), .rst_n(rst_n), .inc(up & lsd_nine), .dec(dn & lsd_zero), .load(do_load), .wrap(wrap),
    .load_val(load_msd), .wrap_to(carry_out ? MIN_B[7:4] : MAX_B[7:4]),
    .q(data_msd), .at_nine(msd_flags_unused[1]), .at_zero(msd_flags_unused[0])
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) load_err <= 1'b0;
    else load_err <= load & ~legal;
endmodule

// File: tb/tb_bcd_modulo_counter.sv
// tb_bcd_modulo_counter: directed checks of range wrap, load validation, conflicts, cascade and async reset.
module tb_bcd_modulo_counter;
  logic clk = 0, rst_n = 0;
  logic [3:0] ld_m = 0, ld_l = 0;
  logic inc0 = 0, dec0 = 0, load0 = 0, inc12 = 0, dec12 = 0, inc23 = 0, load23 = 0;
  logic inc_s = 0, dec_s = 0, load_c = 0;
  logic c0, b0, e0, c12, b12, e12, c23, b23, e23, cs, bs, es, cm, bm, em;
  logic [3:0] m0, l0, m12, l12, m23, l23, ms, ls, mm, lm;
  int total = 0, fails = 0;

  always #5 clk = ~clk;

  bcd_modulo_counter u0 (.clk(clk), .rst_n(rst_n), .inc(inc0), .dec(dec0), .load(load0),
    .load_msd(ld_m), .load_lsd(ld_l), .carry_out(c0), .borrow_out(b0), .load_err(e0),
    .data_msd(m0), .data_lsd(l0));
  bcd_modulo_counter #(.MIN_COUNT(1), .MAX_COUNT(12), .RESET_COUNT(12)) u12 (.clk(clk), .rst_n(rst_n),
    .inc(inc12), .dec(dec12), .load(1'b0), .load_msd(ld_m), .load_lsd(ld_l), .carry_out(c12),
    .borrow_out(b12), .load_err(e12), .data_msd(m12), .data_lsd(l12));
  bcd_modulo_counter #(.MAX_COUNT(23)) u23 (.clk(clk), .rst_n(rst_n), .inc(inc23), .dec(1'b0),
    .load(load23), .load_msd(ld_m), .load_lsd(ld_l), .carry_out(c23), .borrow_out(b23),
    .load_err(e23), .data_msd(m23), .data_lsd(l23));
  bcd_modulo_counter us (.clk(clk), .rst_n(rst_n), .inc(inc_s), .dec(dec_s), .load(load_c),
    .load_msd(ld_m), .load_lsd(ld_l), .carry_out(cs), .borrow_out(bs), .load_err(es),
    .data_msd(ms), .data_lsd(ls));
  bcd_modulo_counter um (.clk(clk), .rst_n(rst_n), .inc(cs), .dec(bs), .load(load_c),
    .load_msd(ld_m), .load_lsd(ld_l), .carry_out(cm), .borrow_out(bm), .load_err(em),
    .data_msd(mm), .data_lsd(lm));

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick; tick;
    chk("rst_u0", {m0, l0}, 8'h00);
    chk("rst_u0_err", 8'(e0), 8'h0);
    chk("rst_u12", {m12, l12}, 8'h12);
    rst_n = 1;
    tick;
    // 1: 60 inc ticks over 00..59
    inc0 = 1;
    for (int i = 0; i < 60; i++) begin
      #1 chk($sformatf("carry_at_%0d", i), 8'(c0), 8'(i == 59));
      tick;
      chk($sformatf("count_after_%0d", i), {m0, l0}, bcd((i + 1) % 60));
    end
    inc0 = 0;
    // 2: 1..12 range wrap both ways
    inc12 = 1;
    #1 chk("u12_carry", 8'(c12), 8'h1);
    tick;
    chk("u12_wrap_up", {m12, l12}, 8'h01);
    inc12 = 0; dec12 = 1;
    #1 chk("u12_borrow", 8'(b12), 8'h1);
    tick;
    chk("u12_wrap_dn", {m12, l12}, 8'h12);
    dec12 = 0;
    // 3: load validation on 0..23, inc ignored during a rejected load
    load23 = 1; inc23 = 1; ld_m = 2; ld_l = 4;
    tick;
    chk("u23_24_hold", {m23, l23}, 8'h00);
    chk("u23_24_err", 8'(e23), 8'h1);
    load23 = 0; inc23 = 0;
    tick;
    chk("u23_err_pulse", 8'(e23), 8'h0);
    load23 = 1; ld_m = 1; ld_l = 4'hA;
    tick;
    chk("u23_1A_hold", {m23, l23}, 8'h00);
    chk("u23_1A_err", 8'(e23), 8'h1);
    ld_l = 9;
    tick;
    chk("u23_19", {m23, l23}, 8'h19);
    chk("u23_19_err", 8'(e23), 8'h0);
    load23 = 0;
    // 4: inc/dec conflict and load priority at 59
    load0 = 1; ld_m = 5; ld_l = 9;
    tick;
    chk("u0_load59", {m0, l0}, 8'h59);
    load0 = 0; inc0 = 1; dec0 = 1;
    #1 chk("conflict_carry", 8'(c0), 8'h0);
    chk("conflict_borrow", 8'(b0), 8'h0);
    tick;
    chk("conflict_hold", {m0, l0}, 8'h59);
    dec0 = 0; load0 = 1; ld_m = 3; ld_l = 0;
    #1 chk("load_inc_carry", 8'(c0), 8'h0);
    tick;
    chk("load_over_inc", {m0, l0}, 8'h30);
    chk("load_over_inc_err", 8'(e0), 8'h0);
    load0 = 0; inc0 = 0;
    // 5: cascaded sec -> min
    load_c = 1; ld_m = 5; ld_l = 9;
    tick;
    load_c = 0;
    chk("casc_load", {mm, lm, ms, ls} >> 8, 8'h59);
    chk("casc_load_s", {ms, ls}, 8'h59);
    inc_s = 1;
    #1 chk("casc_cs", 8'(cs), 8'h1);
    chk("casc_cm", 8'(cm), 8'h1);
    tick;
    inc_s = 0;
    chk("casc_up_s", {ms, ls}, 8'h00);
    chk("casc_up_m", {mm, lm}, 8'h00);
    #1 chk("casc_cm_once", 8'(cm), 8'h0);
    dec_s = 1;
    #1 chk("casc_bs", 8'(bs), 8'h1);
    chk("casc_bm", 8'(bm), 8'h1);
    tick;
    chk("casc_dn_s", {ms, ls}, 8'h59);
    chk("casc_dn_m", {mm, lm}, 8'h59);
    #1 chk("casc_bm_clear", 8'(bm), 8'h0);
    tick;
    dec_s = 0;
    chk("casc_dn2_s", {ms, ls}, 8'h58);
    chk("casc_dn2_m", {mm, lm}, 8'h59);
    // 6: async reset mid-cycle with load_err set and inc in flight
    load0 = 1; ld_m = 3; ld_l = 7;
    tick;
    chk("u0_37", {m0, l0}, 8'h37);
    ld_m = 6; ld_l = 0;
    tick;
    chk("u0_60_err", 8'(e0), 8'h1);
    chk("u0_60_hold", {m0, l0}, 8'h37);
    load0 = 0; inc0 = 1;
    #2 rst_n = 0;
    #1 chk("async_rst_count", {m0, l0}, 8'h00);
    chk("async_rst_err", 8'(e0), 8'h0);
    tick;
    chk("rst_held", {m0, l0}, 8'h00);
    @(negedge clk) rst_n = 1;
    tick;
    chk("resume_01", {m0, l0}, 8'h01);
    inc0 = 0;
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
